addsub_rr_sched: RTL

- Round-robin scheduler that shares one registered compare/add-subtract datapath between NREQ requesters.
- Datapath rule: result = (A > B) ? A + B : A - B, unsigned, modulo 2^WIDTH.
- The block arbitrates requests, sequences one operation at a time through the datapath, and returns the result tagged with the requester index over a valid/ready channel.

---
 rtl/addsub_rr_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one registered compare/add-subtract datapath.
// Optional statistics counters are enabled with the ADDSUB_SCHED_STATS_EN macro.
module addsub_rr_sched #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*WIDTH-1:0] REQ_A,
  input  logic [NREQ*WIDTH-1:0] REQ_B,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [WIDTH-1:0]      RES_DATA,
  output logic [IDW-1:0]        RES_ID
`ifdef ADDSUB_SCHED_STATS_EN
  ,
  output logic [15:0]           OP_COUNT,
  output logic [15:0]           ADD_COUNT
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDW-1:0]   id_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [IDW-1:0]   res_id_q;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand_idx;
  int               cand;

  // Search starting at the pointer; wrap explicitly so non-power-of-two NREQ never yields an out-of-range id.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!grant_found && REQ_VALID[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (state_q == IDLE && grant_found && !RST) REQ_READY[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ADDSUB_SCHED_STATS_EN
  logic res_add_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifdef ADDSUB_SCHED_STATS_EN
      res_add_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (grant_found) begin
          a_q  <= REQ_A[grant_idx*WIDTH +: WIDTH];
          b_q  <= REQ_B[grant_idx*WIDTH +: WIDTH];
          id_q <= grant_idx;
        end
        EXEC: begin
          res_data_q  <= (a_q > b_q) ? a_q + b_q : a_q - b_q;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
`ifdef ADDSUB_SCHED_STATS_EN
          res_add_q   <= (a_q > b_q);
`endif
        end
        DONE: if (RES_READY) begin
          res_valid_q <= 1'b0;
          ptr_q       <= (res_id_q == IDW'(NREQ - 1)) ? '0 : res_id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_ID    = res_id_q;

`ifdef ADDSUB_SCHED_STATS_EN
  logic [15:0] op_count_q, add_count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_count_q  <= '0;
      add_count_q <= '0;
    end else if (res_valid_q && RES_READY) begin
      op_count_q <= op_count_q + 16'd1;
      if (res_add_q) add_count_q <= add_count_q + 16'd1;
    end
  end

  assign OP_COUNT  = op_count_q;
  assign ADD_COUNT = add_count_q;
`endif

endmodule
